// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier; the master drives operands,
// the slave (the multiplier) returns the product, overflow flag, strobe and busy.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   multiplicand_in;
    logic [WIDTH-1:0]   multiplier_in;
    logic               data_valid_in;
    logic [2*WIDTH-1:0] product_out;
    logic               data_valid_out;
    logic               overflow_out;
    logic               busy_out;

    modport master (
        output multiplicand_in,
        output multiplier_in,
        output data_valid_in,
        input  product_out,
        input  data_valid_out,
        input  overflow_out,
        input  busy_out
    );

    modport slave (
        input  multiplicand_in,
        input  multiplier_in,
        input  data_valid_in,
        output product_out,
        output data_valid_out,
        output overflow_out,
        output busy_out
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock, fixed WIDTH-cycle latency.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input logic           clk_in,
    input logic           rst_in,
    seq_multiplier_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        MULTIPLYING
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
`ifdef SEQ_MULT_SIGNED_EN
    logic               sign_q, sign_d;
`endif

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Lower accumulator half holds the not-yet-consumed multiplier bits, so acc_q[0]
    // is always the current multiplier LSB and the final accumulator is the product.
    always_comb begin
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
        step   = {sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
        a_mag  = bus.multiplicand_in[WIDTH-1] ? -bus.multiplicand_in : bus.multiplicand_in;
        b_mag  = bus.multiplier_in[WIDTH-1]   ? -bus.multiplier_in   : bus.multiplier_in;
        result = sign_q ? -step : step;
`else
        a_mag  = bus.multiplicand_in;
        b_mag  = bus.multiplier_in;
        result = step;
`endif
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d     = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.data_valid_in) begin
                    mcand_d = a_mag;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    count_d = CNT_W'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = MULTIPLYING;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d  = bus.multiplicand_in[WIDTH-1] ^ bus.multiplier_in[WIDTH-1];
`endif
                end
            end
            MULTIPLYING: begin
                acc_d   = step;
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    product_d  = result;
`ifdef SEQ_MULT_SIGNED_EN
                    overflow_d = (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
`else
                    overflow_d = (result[2*WIDTH-1:WIDTH] != '0);
`endif
                    valid_d    = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q     <= sign_d;
`endif
        end
    end

    assign bus.product_out    = product_q;
    assign bus.overflow_out   = overflow_q;
    assign bus.data_valid_out = valid_q;
    assign bus.busy_out       = busy_q;
endmodule
